reg_file_param: RTL and testbench

//  Parametrised successor to the 8x8 core register file: two registered read ports, one

---
 rtl/reg_file_param.sv | 144 ++++++++++++++
 tb/tb_reg_file_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parametrised register file sitting between decode and the ALU.
//   - Two registered read ports; data is valid one cycle after readEnable.
//   - Port 2 can be replaced by the immediate operand ltValue.
//   - One write port with its own address.
//   - Sweep-clear engine: a clear request in IDLE zeroes one register per
//     cycle for DEPTH cycles; writes arriving during the sweep are dropped
//     and flagged on writeDrop.
//
// Parameters
//   DW        data width of every register, ltValue and writeData
//   AW        address width, DEPTH = 2**AW
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//
// Optional feature macro
//   REGFILE_BYPASS_EN  forward an accepted write to a read of the same
//                      address in the same cycle
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   readEnable          capture a read this cycle
//   immediate, ltValue  port-2 immediate select and operand
//   readRegister1/2     read addresses
//   regWrite, writeRegister, writeData   write strobe, address, data
//   clear               start a sweep-clear (only looked at in IDLE)
//   readData1/2         registered read data
//   readValid           high the cycle after an accepted read
//   busy                high while the sweep is running
//   writeDrop           one-cycle pulse when a write was dropped by the sweep
//   debugState          current FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake: there is no back-pressure. readEnable is a one-cycle request that
// is always accepted; readValid answers it exactly one cycle later. regWrite is
// accepted whenever busy is low, otherwise it is discarded and writeDrop pulses.
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          readEnable,
  input  logic          immediate,
  input  logic [AW-1:0] readRegister1,
  input  logic [AW-1:0] readRegister2,
  input  logic [DW-1:0] ltValue,
  input  logic          regWrite,
  input  logic [AW-1:0] writeRegister,
  input  logic [DW-1:0] writeData,
  input  logic          clear,
  output logic [DW-1:0] readData1,
  output logic [DW-1:0] readData2,
  output logic          readValid,
  output logic          busy,
  output logic          writeDrop,
  output logic          debugState
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] counter, counter_next;
  logic [DW-1:0] regs [DEPTH];

  logic          wr_accept;
  logic          wr_drop;
  logic [DW-1:0] rd1_val;
  logic [DW-1:0] rd2_val;

  // Writes land only in IDLE; register 0 is write-protected when ZERO_REG is set.
  assign wr_accept = (state == ST_IDLE) && regWrite &&
                     !((ZERO_REG != 0) && (writeRegister == '0));
  assign wr_drop   = (state == ST_CLEAR) && regWrite;

  assign busy       = (state == ST_CLEAR);
  assign debugState = state;

  // Read-side data selection, including optional write forwarding.
  always_comb begin
    rd1_val = ((ZERO_REG != 0) && (readRegister1 == '0)) ? '0 : regs[readRegister1];
    rd2_val = ((ZERO_REG != 0) && (readRegister2 == '0)) ? '0 : regs[readRegister2];
`ifdef REGFILE_BYPASS_EN
    // wr_accept already excludes register 0 under ZERO_REG, so it is never forwarded.
    if (wr_accept && (writeRegister == readRegister1)) rd1_val = writeData;
    if (wr_accept && (writeRegister == readRegister2)) rd2_val = writeData;
`endif
    if (immediate) rd2_val = ltValue;
  end

  // Sweep FSM next-state logic.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_next   = ST_CLEAR;
          counter_next = '0;
        end
      end
      ST_CLEAR: begin
        counter_next = counter + 1'b1;
        if (counter == LAST_IDX) state_next = ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      readData1 <= '0;
      readData2 <= '0;
      readValid <= 1'b0;
      writeDrop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      writeDrop <= wr_drop;
      readValid <= readEnable;
      if (readEnable) begin
        readData1 <= rd1_val;
        readData2 <= rd2_val;
      end
      // wr_accept implies IDLE, so it never collides with the sweep write.
      if (wr_accept) regs[writeRegister] <= writeData;
      if (state == ST_CLEAR) regs[counter] <= '0;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//   Drives two register files in parallel (ZERO_REG = 0 and ZERO_REG = 1) with
//   directed scenarios followed by random traffic. A behavioural model of
//   both instances is updated on every rising edge; a compare process checks
//   every DUT output against it on every falling edge. Directed scenarios add
//   hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

`ifdef REGFILE_BYPASS_EN
  localparam logic [7:0] SAME_CYCLE_EXP = 8'h3C;
`else
  localparam logic [7:0] SAME_CYCLE_EXP = 8'h00;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          readEnable, immediate, regWrite, clear;
  logic [AW-1:0] readRegister1, readRegister2, writeRegister;
  logic [DW-1:0] ltValue, writeData;

  logic [1:0][DW-1:0] rd1, rd2;
  logic [1:0]         valid, busy, drop, dstate;

  reg_file_param #(.DW(DW), .AW(AW), .ZERO_REG(0)) u_dut0 (
    .clock(clock), .reset(reset), .readEnable(readEnable), .immediate(immediate),
    .readRegister1(readRegister1), .readRegister2(readRegister2), .ltValue(ltValue),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .clear(clear), .readData1(rd1[0]), .readData2(rd2[0]), .readValid(valid[0]),
    .busy(busy[0]), .writeDrop(drop[0]), .debugState(dstate[0])
  );

  reg_file_param #(.DW(DW), .AW(AW), .ZERO_REG(1)) u_dut1 (
    .clock(clock), .reset(reset), .readEnable(readEnable), .immediate(immediate),
    .readRegister1(readRegister1), .readRegister2(readRegister2), .ltValue(ltValue),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .clear(clear), .readData1(rd1[1]), .readData2(rd2[1]), .readValid(valid[1]),
    .busy(busy[1]), .writeDrop(drop[1]), .debugState(dstate[1])
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [2][DEPTH];
  logic [7:0] m_rd1 [2];
  logic [7:0] m_rd2 [2];
  bit         m_valid [2];
  bit         m_drop [2];
  bit         m_sweep [2];
  int         m_idx [2];
  bit         live = 0;

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 8'h00;
        m_rd1[k] = 0; m_rd2[k] = 0; m_valid[k] = 0; m_drop[k] = 0;
        m_sweep[k] = 0; m_idx[k] = 0;
        live = 1;
      end else begin
        bit acc;
        acc = !m_sweep[k] && regWrite && !(k == 1 && writeRegister == 0);
        m_drop[k]  = m_sweep[k] && regWrite;
        m_valid[k] = readEnable;
        if (readEnable) begin
          m_rd1[k] = (k == 1 && readRegister1 == 0) ? 8'h00 : m_mem[k][readRegister1];
          m_rd2[k] = (k == 1 && readRegister2 == 0) ? 8'h00 : m_mem[k][readRegister2];
`ifdef REGFILE_BYPASS_EN
          if (acc && writeRegister == readRegister1) m_rd1[k] = writeData;
          if (acc && writeRegister == readRegister2) m_rd2[k] = writeData;
`endif
          if (immediate) m_rd2[k] = ltValue;
        end
        if (acc) m_mem[k][writeRegister] = writeData;
        if (m_sweep[k]) begin
          m_mem[k][m_idx[k]] = 8'h00;
          m_idx[k]++;
          if (m_idx[k] == DEPTH) m_sweep[k] = 0;
        end else if (clear) begin
          m_sweep[k] = 1;
          m_idx[k]   = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_rd1[%0d]", k),   rd1[k],    m_rd1[k]);
        chk($sformatf("model_rd2[%0d]", k),   rd2[k],    m_rd2[k]);
        chk($sformatf("model_valid[%0d]", k), valid[k],  m_valid[k]);
        chk($sformatf("model_busy[%0d]", k),  busy[k],   m_sweep[k]);
        chk($sformatf("model_drop[%0d]", k),  drop[k],   m_drop[k]);
        chk($sformatf("model_state[%0d]", k), dstate[k], m_sweep[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic re, input logic [2:0] a1, input logic [2:0] a2,
                     input logic imm, input logic [7:0] lt, input logic clr);
    regWrite = we; writeRegister = wa; writeData = wd;
    readEnable = re; readRegister1 = a1; readRegister2 = a2;
    immediate = imm; ltValue = lt; clear = clr;
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 1, 3'(i), 3'(i), 0, 0, 0);
      chk({tag, "_rd1"}, rd1[0], 8'h00);
      chk({tag, "_rd2"}, rd2[0], 8'h00);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    reset = 1;
    regWrite = 0; writeRegister = 0; writeData = 0; readEnable = 0;
    readRegister1 = 0; readRegister2 = 0; immediate = 0; ltValue = 0; clear = 0;
    step(); step();
    chk("reset_rd1", rd1[0], 8'h00);
    chk("reset_valid", valid[0], 1'b0);
    chk("reset_busy", busy[0], 1'b0);
    reset = 0;

    // 1: write then read same register on both ports
    cyc(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 3, 0, 0, 0);
    chk("t1_rd1", rd1[0], 8'hA5);
    chk("t1_rd2", rd2[0], 8'hA5);
    chk("t1_valid", valid[0], 1'b1);
    idle();
    chk("t1_valid_drop", valid[0], 1'b0);
    chk("t1_hold", rd1[0], 8'hA5);

    // 2: immediate select on port 2
    cyc(1, 2, 8'h11, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 2, 1, 8'h7F, 0);
    chk("t2_rd1", rd1[0], 8'h11);
    chk("t2_rd2", rd2[0], 8'h7F);

    // 3: same-cycle write and read
    cyc(1, 5, 8'h3C, 1, 5, 0, 0, 0, 0);
    chk("t3_same", rd1[0], SAME_CYCLE_EXP);
    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("t3_next", rd1[0], 8'h3C);

    // 4: fill, sweep, dropped write in sweep cycle 4
    for (int i = 0; i < DEPTH; i++) cyc(1, 3'(i), 8'(i + 1), 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_busy_start", busy[0], 1'b1);
    cnt = 1;
    for (int guard = 0; guard < 20; guard++) begin
      cyc(cnt == 4, 6, 8'hEE, 0, 0, 0, 0, 0, 0);
      if (cnt == 4) chk("t4_drop", drop[0], 1'b1);
      if (busy[0]) cnt++;
      else break;
    end
    chk("t4_busy_cycles", cnt, 8);
    chk("t4_drop_clear", drop[0], 1'b0);
    read_all_zero("t4");

    // 5: ZERO_REG register 0
    cyc(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0);
    chk("t5_nodrop", drop[1], 1'b0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("t5_zr_rd1", rd1[1], 8'h00);
    chk("t5_zr_rd2", rd2[1], 8'h00);
    chk("t5_plain_rd1", rd1[0], 8'hFF);

    // 6: reset in the middle of a sweep
    for (int i = 0; i < DEPTH; i++) cyc(1, 3'(i), 8'h55, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 4, 0, 0, 1);
    idle(); idle();
    reset = 1;
    idle();
    reset = 0;
    chk("t6_busy", busy[0], 1'b0);
    chk("t6_rd1", rd1[0], 8'h00);
    chk("t6_rd2", rd2[0], 8'h00);
    chk("t6_valid", valid[0], 1'b0);
    chk("t6_drop", drop[0], 1'b0);
    chk("t6_state", dstate[0], 1'b0);
    read_all_zero("t6");

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          $urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 39) == 0));
    end
    reset = 0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
